// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and default widths.
package div_pkg;

  localparam int DD_W_DEF = 32;
  localparam int DV_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/div_abs.sv
// Magnitude and sign of a W-bit operand; sign is forced to 0 when is_signed is low.
module div_abs #(
  parameter int W = 16
) (
  input  logic [W-1:0] value,
  input  logic         is_signed,
  output logic [W-1:0] mag,
  output logic         neg
);

  assign neg = is_signed & value[W-1];
  // The most negative value maps onto itself, which is the correct unsigned magnitude.
  assign mag = neg ? (~value + 1'b1) : value;

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider, one quotient bit per cycle with a valid/ready handshake on both sides.
// Defining DIV_ITER_SIGNED_EN adds the signed_op port and two's-complement operation.
module div_iter
  import div_pkg::*;
#(
  parameter int DD_W = DD_W_DEF,
  parameter int DV_W = DV_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DD_W-1:0]      dividend,
  input  logic [DV_W-1:0]      divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DD_W-DV_W-1:0] quotient,
  output logic [DV_W-1:0]      remainder,
  output logic                 div_zero,
  output logic                 overflow
`ifdef DIV_ITER_SIGNED_EN
  ,
  input  logic                 signed_op
`endif
);

  localparam int QW = DD_W - DV_W;
  localparam int CW = $clog2(QW + 1);

  state_t          state;
  logic            is_signed;
  logic [DD_W-1:0] dd_mag;
  logic [DV_W-1:0] dv_mag;
  logic            dd_neg;
  logic            dv_neg;
  logic            accept;
  logic            in_big;

  logic [DV_W-1:0] part_rem;
  logic [QW-1:0]   acc;
  logic [DV_W-1:0] dv_reg;
  logic [CW-1:0]   count;
  logic [DV_W:0]   trial;
  logic [DV_W-1:0] diff;
  logic            take;

  logic [QW-1:0]   fix_q;
  logic [DV_W-1:0] fix_r;
  logic            fix_ovf;

`ifdef DIV_ITER_SIGNED_EN
  localparam logic [QW-1:0] Q_POS_MAX = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] Q_NEG_MAX = {1'b1, {(QW-1){1'b0}}};
  logic mode_reg;
  logic q_neg;
  logic r_neg;
  assign is_signed = signed_op;
`else
  logic unused_sign;
  assign is_signed   = 1'b0;
  assign unused_sign = dd_neg | dv_neg;
`endif

  div_abs #(.W(DD_W)) u_abs_dd (
    .value     (dividend),
    .is_signed (is_signed),
    .mag       (dd_mag),
    .neg       (dd_neg)
  );

  div_abs #(.W(DV_W)) u_abs_dv (
    .value     (divisor),
    .is_signed (is_signed),
    .mag       (dv_mag),
    .neg       (dv_neg)
  );

  assign accept = (state == IDLE) && in_valid;
  assign in_big = dd_mag[DD_W-1:QW] >= dv_mag;

  // Partial remainder is always below the divisor, so the restored value fits DV_W bits.
  assign trial = {part_rem, acc[QW-1]};
  assign take  = trial >= {1'b0, dv_reg};
  assign diff  = trial[DV_W-1:0] - dv_reg;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    fix_ovf = 1'b0;
    fix_q   = acc;
    fix_r   = part_rem;
`ifdef DIV_ITER_SIGNED_EN
    if (mode_reg) begin
      fix_ovf = q_neg ? (acc > Q_NEG_MAX) : (acc > Q_POS_MAX);
      if (q_neg) fix_q = ~acc + 1'b1;
      if (r_neg) fix_r = ~part_rem + 1'b1;
      if (fix_ovf) begin
        fix_q = '1;
        fix_r = '0;
      end
    end
`endif
  end

  // NOTE: datapath registers carry no reset; the FSM never consumes them before an accept loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      part_rem <= dd_mag[DD_W-1:QW];
      acc      <= dd_mag[QW-1:0];
      dv_reg   <= dv_mag;
`ifdef DIV_ITER_SIGNED_EN
      mode_reg <= is_signed;
      q_neg    <= dd_neg ^ dv_neg;
      r_neg    <= dd_neg;
`endif
    end else if (state == ITER) begin
      part_rem <= take ? diff : trial[DV_W-1:0];
      acc      <= {acc[QW-2:0], take};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            count    <= '0;
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              div_zero  <= 1'b1;
              overflow  <= 1'b0;
              quotient  <= '1;
              remainder <= dividend[DV_W-1:0];
            end else if (in_big) begin
              state     <= DONE;
              out_valid <= 1'b1;
              div_zero  <= 1'b0;
              overflow  <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
            end else begin
              state <= ITER;
            end
          end
        end
        ITER: begin
          count <= count + 1'b1;
          if (count == CW'(QW - 1)) state <= FIX;
        end
        FIX: begin
          state     <= DONE;
          out_valid <= 1'b1;
          div_zero  <= 1'b0;
          overflow  <= fix_ovf;
          quotient  <= fix_q;
          remainder <= fix_r;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases plus random operands against an arithmetic model.
// Signed tests are compiled in when DIV_ITER_SIGNED_EN is defined.
module tb_div_iter;

  localparam int DD_W = 32;
  localparam int DV_W = 16;
  localparam int QW   = DD_W - DV_W;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [DD_W-1:0] dividend;
  logic [DV_W-1:0] divisor;
  logic            out_valid;
  logic            out_ready;
  logic [QW-1:0]   quotient;
  logic [DV_W-1:0] remainder;
  logic            div_zero;
  logic            overflow;
`ifdef DIV_ITER_SIGNED_EN
  logic            signed_op;
`endif

  int n_cmp = 0;
  int n_err = 0;

  div_iter #(.DD_W(DD_W), .DV_W(DV_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
`ifdef DIV_ITER_SIGNED_EN
    ,
    .signed_op (signed_op)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: true integer division, with the range limits of the quotient port.
  task automatic model(input logic [DD_W-1:0] dd, input logic [DV_W-1:0] dv, input bit sop,
                       output logic [QW-1:0] q, output logic [DV_W-1:0] r,
                       output bit dz, output bit ov, output int lat);
    longint a, b, qq, rr;
    dz = 0; ov = 0; lat = QW + 2; q = '0; r = '0;
    if (dv == '0) begin
      dz = 1; lat = 1; q = '1; r = dd[DV_W-1:0];
      return;
    end
    if (sop) begin
      a = longint'($signed(dd));
      b = longint'($signed(dv));
    end else begin
      a = longint'(dd);
      b = longint'(dv);
    end
    if (((a < 0 ? -a : a) / (b < 0 ? -b : b)) >= (64'sd1 << QW)) begin
      ov = 1; lat = 1; q = '1; r = '0;
      return;
    end
    qq = a / b;
    rr = a % b;
    if (sop && (qq > (64'sd1 << (QW - 1)) - 1 || qq < -(64'sd1 << (QW - 1)))) begin
      ov = 1; q = '1; r = '0;
    end else begin
      q = qq[QW-1:0];
      r = rr[DV_W-1:0];
    end
  endtask

  task automatic run_op(input logic [DD_W-1:0] dd, input logic [DV_W-1:0] dv, input bit sop,
                        input int hold, input string tag);
    logic [QW-1:0]   eq;
    logic [DV_W-1:0] er;
    bit              edz, eov;
    int              elat, lat;
    model(dd, dv, sop, eq, er, edz, eov, elat);
    @(negedge clk);
    check({tag, ".in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
`ifdef DIV_ITER_SIGNED_EN
    signed_op = sop;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = DV_W'($urandom);
`ifdef DIV_ITER_SIGNED_EN
    signed_op = ~sop;
`endif
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, lat, elat);
    check({tag, ".quotient"}, quotient, eq);
    check({tag, ".remainder"}, remainder, er);
    check({tag, ".div_zero"}, div_zero, edz);
    check({tag, ".overflow"}, overflow, eov);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, out_valid, 1);
      check({tag, ".hold_in_ready"}, in_ready, 0);
      check({tag, ".hold_quotient"}, quotient, eq);
      check({tag, ".hold_remainder"}, remainder, er);
    end
    // in_valid stays high across the release edge; it must not be taken as a new operation.
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, ".release_in_ready"}, in_ready, 1);
    check({tag, ".release_out_valid"}, out_valid, 0);
  endtask

  initial begin
    logic [DD_W-1:0] dd;
    logic [DV_W-1:0] dv;
    bit              sop;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
`ifdef DIV_ITER_SIGNED_EN
    signed_op = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset.in_ready", in_ready, 1);
    check("reset.out_valid", out_valid, 0);
    check("reset.quotient", quotient, 0);
    check("reset.remainder", remainder, 0);
    check("reset.flags", {div_zero, overflow}, 0);
    @(negedge clk);
    reset = 1'b0;

    run_op(32'd100000, 16'd7, 1'b0, 0, "udiv");
    run_op(32'h12345678, 16'd0, 1'b0, 0, "divzero");
    run_op(32'h00070000, 16'd7, 1'b0, 0, "ovf");
    run_op(32'h0006FFFF, 16'd7, 1'b0, 0, "ovf_edge");
    run_op(32'hFFFEFFFF, 16'hFFFF, 1'b0, 0, "max_q");
    run_op(32'd123456789, 16'd40000, 1'b0, 5, "backpressure");
`ifdef DIV_ITER_SIGNED_EN
    run_op(-32'sd100000, 16'd7, 1'b1, 0, "sdiv");
    run_op(32'sd100000, -16'sd7, 1'b1, 0, "sdiv_negdv");
    run_op(-32'sd100000, -16'sd7, 1'b1, 0, "sdiv_both");
    run_op(32'h00008000, 16'd1, 1'b1, 0, "s_pos_ovf");
    run_op(-32'sd32768, 16'd1, 1'b1, 0, "s_neg_edge");
    run_op(32'h80000000, 16'h8000, 1'b1, 0, "s_minmin");
`endif

    // Reset on the 5th ITER cycle, with in_valid high to show reset wins.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 32'd100000;
    divisor  = 16'd7;
`ifdef DIV_ITER_SIGNED_EN
    signed_op = 1'b0;
`endif
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset.out_valid", out_valid, 0);
    check("midreset.in_ready", in_ready, 1);
    check("midreset.quotient", quotient, 0);
    check("midreset.remainder", remainder, 0);
    check("midreset.flags", {div_zero, overflow}, 0);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;

    for (int n = 0; n < 60; n++) begin
      dv = DV_W'($urandom);
      if ($urandom_range(0, 15) == 0) dv = '0;
      dd = $urandom;
      sop = 1'b0;
`ifdef DIV_ITER_SIGNED_EN
      sop = bit'($urandom_range(0, 1));
`endif
      // Bias most operations into the non-overflow range so iteration is exercised.
      if (!sop && dv != '0 && $urandom_range(0, 3) != 0)
        dd = {DV_W'($urandom_range(0, int'(dv) - 1)), QW'($urandom)};
      run_op(dd, dv, sop, $urandom_range(0, 2), $sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 Parameter DD_W, default 32, dividend width in bits.
REQ-002 Parameter DV_W, default 16, divisor and remainder width; DD_W > DV_W required.
REQ-003 Derived constant QW = DD_W - DV_W, quotient width; not overridable.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operands valid.
REQ-007 in_ready  output  1  block accepts operands.
REQ-008 dividend  input  DD_W  dividend operand.
REQ-009 divisor  input  DV_W  divisor operand.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 quotient  output  QW  result quotient.
REQ-013 remainder  output  DV_W  result remainder.
REQ-014 div_zero  output  1  divisor was zero.
REQ-015 overflow  output  1  quotient not representable in QW bits.

Function
REQ-016 The FSM SHALL have states IDLE, ITER, FIX and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 Accept SHALL occur on an edge with in_valid=1 in IDLE; operands and operation mode SHALL be captured at that edge.
REQ-019 On accept with divisor=0, the block SHALL go to DONE with div_zero=1, quotient=all ones, remainder=dividend[DV_W-1:0].
REQ-020 Otherwise, on accept with |dividend|[DD_W-1:QW] >= |divisor|, the block SHALL go to DONE with overflow=1, quotient=all ones, remainder=0.
REQ-021 Otherwise the block SHALL enter ITER and run QW restoring iterations, one quotient bit per cycle, MSB first, on magnitudes, using a DV_W+1-bit partial remainder.
REQ-022 After the QW-th iteration the block SHALL enter FIX for one cycle to apply signs, then enter DONE.
REQ-023 Normal latency SHALL be QW+2 edges from accept until out_valid=1; error latency SHALL be 1 edge.
REQ-024 In DONE all result outputs SHALL hold stable until an edge with out_ready=1; that edge SHALL return the FSM to IDLE.
REQ-025 in_valid in any state other than IDLE SHALL be ignored; no operand SHALL be accepted on the DONE->IDLE edge.
REQ-026 div_zero and overflow SHALL be mutually exclusive; div_zero SHALL take priority.

Reset
REQ-027 With reset=1 at an edge, the block SHALL enter IDLE and set quotient, remainder, div_zero, overflow and out_valid to 0, in any state, including mid-ITER.
REQ-028 reset SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-029 With macro DIV_ITER_SIGNED_EN defined, an input port signed_op (1 bit) SHALL exist.
REQ-030 signed_op=1 SHALL make the block treat the operands as two's complement.
REQ-031 In signed mode, the quotient SHALL truncate toward zero, and the remainder sign SHALL equal the dividend sign.
REQ-032 In signed mode, FIX SHALL set overflow=1 when the magnitude quotient exceeds 2^(QW-1)-1 for a positive result or 2^(QW-1) for a negative result, applying the REQ-020 output values.
REQ-033 Without DIV_ITER_SIGNED_EN, signed_op SHALL be absent, all operations SHALL be unsigned, and no sign logic SHALL be synthesised.

Structure
REQ-034 A shared package div_pkg SHALL hold the FSM state enum and the default width constants DD_W_DEF=32 and DV_W_DEF=16.
REQ-035 One sub-module, div_abs, SHALL compute the magnitude and sign of a parametrised-width operand; it SHALL be instantiated for the dividend and for the divisor.

Verification (DD_W=32, DV_W=16)
REQ-036 Unsigned divide: 100000/7 -> quotient=14285, remainder=5, flags 0, out_valid exactly 18 edges after accept.
REQ-037 Divide by zero: 0x12345678/0 -> out_valid 1 edge after accept, div_zero=1, quotient=0xFFFF, remainder=0x5678.
REQ-038 Overflow: 0x00070000/7 -> overflow=1, quotient=0xFFFF, remainder=0, latency 1 edge.
REQ-039 Backpressure: out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> in_ready=1 on the next cycle.
REQ-040 Reset mid-operation: reset at the 5th ITER cycle -> next cycle out_valid=0, in_ready=1, all outputs 0.
REQ-041 Signed divide (DIV_ITER_SIGNED_EN defined): -100000/7 with signed_op=1 -> quotient=0xC833 (-14285), remainder=0xFFFB (-5).
